// File: rtl/mac_sched.sv
// Two-requester job scheduler in front of an external pipelined MAC.
// Arbitrates whole jobs, streams operand beats, tracks in-flight results and returns the final accumulator.
module mac_sched #(
    parameter int MAX_BEATS = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rq0_valid,
    input  logic signed [7:0]  rq0_a,
    input  logic signed [7:0]  rq0_b,
    input  logic               rq0_last,
    output logic               rq0_ready,
    input  logic               rq1_valid,
    input  logic signed [7:0]  rq1_a,
    input  logic signed [7:0]  rq1_b,
    input  logic               rq1_last,
    output logic               rq1_ready,
    output logic signed [7:0]  mac_a,
    output logic signed [7:0]  mac_b,
    output logic               mac_valid_in,
    output logic               mac_clear,
    input  logic signed [15:0] mac_f,
    input  logic               mac_valid_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic signed [15:0] res_data,
    output logic               res_trunc
);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_t            state, state_nx;
    logic              grant, prio, trunc_flag;
    logic [7:0]        issued, returned;
    logic              sel_valid, sel_last, accept, hit_max, capture, count_ret;
    logic signed [7:0] sel_a, sel_b;

    always_comb begin
        sel_valid = grant ? rq1_valid : rq0_valid;
        sel_last  = grant ? rq1_last  : rq0_last;
        sel_a     = grant ? rq1_a     : rq0_a;
        sel_b     = grant ? rq1_b     : rq0_b;
        accept    = (state == STREAM) && sel_valid;
        hit_max   = (issued + 8'd1) == MAX_B;
        capture   = (state == DRAIN) && mac_valid_out && ((returned + 8'd1) == issued);
        count_ret = mac_valid_out && ((state == STREAM) || (state == DRAIN));
        state_nx  = state;
        case (state)
            IDLE:    if (rq0_valid || rq1_valid) state_nx = CLEAR;
            CLEAR:   state_nx = STREAM;
            STREAM:  if (accept && (sel_last || hit_max)) state_nx = DRAIN;
            DRAIN:   if (capture) state_nx = RESULT;
            RESULT:  if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rq0_ready = (state == STREAM) && !grant;
    assign rq1_ready = (state == STREAM) && grant;
    assign res_valid = (state == RESULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant        <= 1'b0;
            prio         <= 1'b0;
            trunc_flag   <= 1'b0;
            issued       <= '0;
            returned     <= '0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_clear    <= 1'b1;
            res_id       <= 1'b0;
            res_data     <= '0;
            res_trunc    <= 1'b0;
        end else begin
            state        <= state_nx;
            // registered so the MAC sees its clear exactly while the FSM sits in CLEAR
            mac_clear    <= (state_nx == CLEAR);
            mac_valid_in <= accept;
            if (accept) begin
                mac_a <= sel_a;
                mac_b <= sel_b;
            end
            if ((state == IDLE) && (rq0_valid || rq1_valid))
                grant <= rq1_valid && (!rq0_valid || prio);
            if (state == CLEAR) begin
                issued   <= '0;
                returned <= '0;
            end else begin
                if (accept)    issued   <= issued + 8'd1;
                if (count_ret) returned <= returned + 8'd1;
            end
            if (accept && hit_max && !sel_last)
                trunc_flag <= 1'b1;
            if (capture) begin
                res_data  <= mac_f;
                res_id    <= grant;
                res_trunc <= trunc_flag;
            end
            if ((state == RESULT) && res_ready) begin
                prio       <= ~grant;
                trunc_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Randomised and directed bench for mac_sched with a 3-cycle MAC model and a per-requester job scoreboard.
module tb_mac_sched;

    localparam int MAXB = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rq0_valid, rq0_last, rq0_ready;
    logic               rq1_valid, rq1_last, rq1_ready;
    logic signed [7:0]  rq0_a, rq0_b, rq1_a, rq1_b;
    logic signed [7:0]  mac_a, mac_b;
    logic               mac_valid_in, mac_clear, mac_valid_out;
    logic signed [15:0] mac_f;
    logic               res_valid, res_ready, res_id, res_trunc;
    logic signed [15:0] res_data;

    always #5 clk = ~clk;

    mac_sched #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_last(rq0_last), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_last(rq1_last), .rq1_ready(rq1_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clear(mac_clear),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .res_trunc(res_trunc)
    );

    // External MAC: accumulates on mac_valid_in, result strobe three cycles later
    logic [2:0]         vp;
    logic signed [15:0] acc, fp0, fp1, fp2, prod;
    assign prod = {{8{mac_a[7]}}, mac_a} * {{8{mac_b[7]}}, mac_b};
    always @(posedge clk) begin
        if (mac_clear) begin
            acc <= '0;
            vp  <= '0;
        end else begin
            vp <= {vp[1:0], mac_valid_in};
            if (mac_valid_in) begin
                acc <= acc + prod;
                fp0 <= acc + prod;
            end
            fp1 <= fp0;
            fp2 <= fp1;
        end
    end
    assign mac_valid_out = vp[2];
    assign mac_f         = fp2;

    typedef struct packed {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic signed [15:0] sum;
        logic [7:0]         len;
        logic               trunc;
    } job_t;

    beat_t              bq[2][$];
    job_t               ej[2][$];
    int                 open_sum[2];
    int                 open_len[2];
    int                 id_log[$];
    logic signed [15:0] data_log[$];
    logic               trunc_log[$];

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   acc_beats = 0;
    logic gappy = 1'b0, rr_rand = 1'b0, hold_low = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Jobs are cut by the last flag or by reaching MAXB beats
    function automatic void push_beat(int r, logic signed [7:0] a, logic signed [7:0] b, logic last);
        beat_t bt;
        bt.a = a; bt.b = b; bt.last = last;
        bq[r].push_back(bt);
        open_sum[r] += int'(a) * int'(b);
        open_len[r]++;
        if (last || open_len[r] == MAXB) begin
            job_t j;
            j.sum   = 16'(open_sum[r]);
            j.len   = 8'(open_len[r]);
            j.trunc = !last;
            ej[r].push_back(j);
            open_sum[r] = 0;
            open_len[r] = 0;
        end
    endfunction

    function automatic void push_rand_job(int r, int len);
        for (int k = 0; k < len; k++)
            push_beat(r, 8'($urandom), 8'($urandom), k == len - 1);
    endfunction

    function automatic void flush_model();
        for (int r = 0; r < 2; r++) begin
            bq[r].delete();
            ej[r].delete();
            open_sum[r] = 0;
            open_len[r] = 0;
        end
    endfunction

    task automatic drive();
        beat_t b0, b1;
        b0 = '0;
        b1 = '0;
        if (bq[0].size() > 0) b0 = bq[0][0];
        if (bq[1].size() > 0) b1 = bq[1][0];
        rq0_valid = (bq[0].size() > 0) && (!gappy || ($urandom_range(0, 3) != 0));
        rq1_valid = (bq[1].size() > 0) && (!gappy || ($urandom_range(0, 3) != 0));
        {rq0_a, rq0_b, rq0_last} = {b0.a, b0.b, b0.last};
        {rq1_a, rq1_b, rq1_last} = {b1.a, b1.b, b1.last};
        res_ready = hold_low ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic cycle();
        logic a0, a1;
        a0 = rq0_valid && rq0_ready;
        a1 = rq1_valid && rq1_ready;
        @(posedge clk);
        #2;
        if (a0) begin void'(bq[0].pop_front()); acc_beats++; end
        if (a1) begin void'(bq[1].pop_front()); acc_beats++; end
        drive();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((bq[0].size() + bq[1].size() + ej[0].size() + ej[1].size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("outstanding_work", bq[0].size() + bq[1].size() + ej[0].size() + ej[1].size(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_readys", {rq0_ready, rq1_ready}, 0);
        chk("rst_mac_ab", {mac_a, mac_b}, 0);
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_trunc", res_trunc, 0);
    endtask

    // Monitor: handshake scoreboard, pulse counting and RESULT-hold rules
    logic               pv = 1'b0, phs = 1'b0, pid, ptr;
    logic signed [15:0] pdata;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            pulses = 0;
            pv = 1'b0;
            phs = 1'b0;
        end else begin
            chk("ready_exclusive", rq0_ready & rq1_ready, 0);
            if (mac_valid_in) pulses++;
            if (res_valid) begin
                chk("result_readys", {rq0_ready, rq1_ready}, 0);
                chk("result_mac_valid_in", mac_valid_in, 0);
                if (pv && !phs) begin
                    chk("hold_data", res_data, pdata);
                    chk("hold_id", res_id, pid);
                    chk("hold_trunc", res_trunc, ptr);
                end
            end
            if (res_valid && res_ready) begin
                if (ej[res_id].size() == 0) begin
                    chk("unexpected_result", ej[res_id].size(), 1);
                end else begin
                    job_t j;
                    j = ej[res_id].pop_front();
                    chk("res_data", res_data, j.sum);
                    chk("res_trunc", res_trunc, j.trunc);
                    chk("beat_pulses", pulses, j.len);
                end
                id_log.push_back(int'(res_id));
                data_log.push_back(res_data);
                trunc_log.push_back(res_trunc);
                pulses = 0;
            end
            pv    = res_valid;
            phs   = res_valid && res_ready;
            pdata = res_data;
            pid   = res_id;
            ptr   = res_trunc;
        end
    end

    initial begin
        int n;
        logic signed [15:0] held;
        flush_model();
        drive();
        #1 reset = 1'b0;
        #2 check_reset_outputs();

        // Both requesters valid on the first cycle after reset; rq0 carries the reference job
        push_beat(0, 8'sd3, 8'sd4, 1'b0);
        push_beat(0, -8'sd2, 8'sd5, 1'b0);
        push_beat(0, 8'sd7, -8'sd1, 1'b1);
        push_rand_job(1, 2);
        @(posedge clk);
        #2 drive();
        reset = 1'b1;
        #1 chk("clear_after_release", mac_clear, 1);
        wait_done(200);
        chk("order_first", id_log.size() > 0 ? id_log[0] : -1, 0);
        chk("order_second", id_log.size() > 1 ? id_log[1] : -1, 1);
        chk("ref_job_sum", data_log.size() > 0 ? data_log[0] : 16'sh7fff, -16'sd5);

        // rq0 keeps requesting while rq1 waits: service alternates
        id_log.delete();
        push_rand_job(0, 2);
        push_rand_job(0, 3);
        push_rand_job(1, 1);
        drive();
        wait_done(300);
        chk("alt_0", id_log.size() > 0 ? id_log[0] : -1, 0);
        chk("alt_1", id_log.size() > 1 ? id_log[1] : -1, 1);
        chk("alt_2", id_log.size() > 2 ? id_log[2] : -1, 0);

        // Truncation at MAXB beats; the remainder opens the next job
        id_log.delete(); data_log.delete(); trunc_log.delete();
        for (int k = 0; k < 6; k++) push_beat(0, 8'sd1, 8'sd1, 1'b0);
        push_beat(0, 8'sd2, 8'sd3, 1'b1);
        drive();
        wait_done(300);
        chk("trunc_sum", data_log.size() > 0 ? data_log[0] : 16'sh7fff, 4);
        chk("trunc_flag", trunc_log.size() > 0 ? trunc_log[0] : 1'bx, 1);
        chk("after_trunc_sum", data_log.size() > 1 ? data_log[1] : 16'sh7fff, 8);
        chk("after_trunc_flag", trunc_log.size() > 1 ? trunc_log[1] : 1'bx, 0);

        // Consumer stalls for 10 cycles in RESULT
        hold_low = 1'b1;
        push_rand_job(1, 2);
        drive();
        n = 0;
        while (!res_valid && n < 50) begin cycle(); n++; end
        chk("stall_reached_result", res_valid, 1);
        held = res_data;
        for (int k = 0; k < 10; k++) cycle();
        chk("stall_res_valid", res_valid, 1);
        chk("stall_res_data", res_data, held);
        hold_low = 1'b0;
        drive();
        wait_done(100);

        // Minimum turnaround for a one-beat job with res_ready high
        push_rand_job(1, 1);
        drive();
        n = 0;
        while (!res_valid && n < 30) begin cycle(); n++; end
        chk("turnaround_cycles", n, 7);
        wait_done(50);

        // Reset during STREAM after two beats aborts the job
        push_rand_job(0, 4);
        acc_beats = 0;
        drive();
        n = 0;
        while (acc_beats < 2 && n < 50) begin cycle(); n++; end
        chk("beats_before_abort", acc_beats, 2);
        reset = 1'b0;
        #1 check_reset_outputs();
        flush_model();
        drive();
        cycle();
        cycle();
        chk("abort_no_result", res_valid, 0);
        reset = 1'b1;
        #1 chk("clear_first_edge", mac_clear, 1);
        cycle();
        chk("clear_drops", mac_clear, 0);
        push_beat(1, -8'sd9, 8'sd11, 1'b0);
        push_beat(1, 8'sd100, 8'sd100, 1'b1);
        data_log.delete();
        drive();
        wait_done(100);
        chk("post_reset_sum", data_log.size() > 0 ? data_log[0] : 16'sh7fff, 16'(-99 + 10000));

        // Random traffic with valid gaps and random res_ready
        gappy = 1'b1;
        rr_rand = 1'b1;
        for (int k = 0; k < 40; k++)
            push_rand_job(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
        drive();
        wait_done(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Parameters
REQ-001 The block SHALL have parameter MAX_BEATS, default 255, meaning the maximum number of beats accepted per job (range 1..255).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports rq0_valid / rq1_valid, input, 1 bit each: requester has a beat.
REQ-005 The block SHALL have ports rq0_a, rq0_b, rq1_a, rq1_b, input, 8 bits each, signed: operand pair for the beat.
REQ-006 The block SHALL have ports rq0_last / rq1_last, input, 1 bit each: the beat is the final beat of the job.
REQ-007 The block SHALL have ports rq0_ready / rq1_ready, output, 1 bit each: beat accepted when valid and ready are both high at a clock edge.
REQ-008 The block SHALL have ports mac_a / mac_b, output, 8 bits each, signed: registered operands to the MAC.
REQ-009 The block SHALL have port mac_valid_in, output, 1 bit: operand strobe to the MAC.
REQ-010 The block SHALL have port mac_clear, output, 1 bit: active-high synchronous reset to the MAC.
REQ-011 The block SHALL have ports mac_f (input, 16 bits, signed) and mac_valid_out (input, 1 bit): MAC accumulator and its result strobe.
REQ-012 The block SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit), res_id (output, 1 bit), res_data (output, 16 bits, signed) and res_trunc (output, 1 bit): the result handshake.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, STREAM, DRAIN and RESULT.
REQ-014 IDLE: if any rqX_valid is high, the block SHALL latch grant (rq1 only valid -> 1, rq0 only -> 0, both -> prio) and go to CLEAR.
REQ-015 CLEAR: mac_clear SHALL be 1 for exactly one cycle, the issued and returned counters SHALL be zeroed, and the FSM SHALL go to STREAM.
REQ-016 STREAM: rqX_ready SHALL be 1 only for the granted requester; the non-granted ready SHALL be 0 in all states.
REQ-017 On each accepted beat, the block SHALL register a/b onto mac_a/mac_b and assert mac_valid_in on the next cycle only (1-cycle pulse per beat); the issued counter SHALL be incremented.
REQ-018 An accepted beat with last=1 SHALL move the FSM to DRAIN.
REQ-019 An accepted beat that makes issued == MAX_BEATS with last=0 SHALL also move the FSM to DRAIN and set the truncation flag.
REQ-020 DRAIN: ready SHALL be 0, and each mac_valid_out pulse SHALL increment the returned counter.
REQ-021 In DRAIN, on the cycle mac_valid_out is high and returned+1 == issued, mac_f SHALL be captured into res_data, res_id SHALL be set to grant, res_trunc SHALL be set to the flag, and the FSM SHALL go to RESULT.
REQ-022 mac_valid_out pulses in STREAM SHALL also be counted.
REQ-023 mac_valid_out pulses in IDLE, CLEAR or RESULT SHALL be ignored.
REQ-024 RESULT: res_valid SHALL be 1 and res_* SHALL be held stable until res_ready=1; on handshake, prio SHALL be set to ~grant, the flag SHALL be cleared, and the FSM SHALL go to IDLE.
REQ-025 When res_ready is already high on entry to RESULT, res_valid SHALL be high for exactly one cycle.
REQ-026 Arithmetic SHALL NOT be performed by this block; res_data SHALL equal the MAC's 16-bit wrapped accumulator.
REQ-027 Minimum job turnaround (1 beat, res_ready high) SHALL be: IDLE->CLEAR 1 cycle, CLEAR->STREAM 1, accept, mac_valid_in +1, MAC latency 3, capture, RESULT 1.
REQ-028 A requester dropping valid mid-job SHALL hold the FSM in STREAM indefinitely with no timeout.

Reset
REQ-029 On reset low, all outputs SHALL go immediately to the following values: state=IDLE, prio=0, rq0_ready=rq1_ready=0, mac_a=mac_b=0, mac_valid_in=0, mac_clear=1, res_valid=0, res_id=0, res_data=0, res_trunc=0, counters=0.
REQ-030 After reset deasserts, mac_clear SHALL stay 1 for the first clock edge, then go to 0.
REQ-031 Reset asserted mid-job SHALL abort the job with no result produced.

Verification
REQ-032 Single job, rq0: beats (3,4), (-2,5), (7,-1, last) with res_ready=1 -> exactly 3 mac_valid_in pulses, then res_valid with res_id=0, res_data=-5, res_trunc=0.
REQ-033 rq0 and rq1 both valid on the first cycle after reset -> rq0 served first; on the next job rq1 served with res_id=1.
REQ-034 rq0 continuously requesting while rq1 waits -> jobs alternate 0,1,0.
REQ-035 With MAX_BEATS=4, rq0 sends 6 beats of (1,1), never last -> 4 beats accepted, res_data=4, res_trunc=1; the remaining 2 beats are taken by the next rq0 job.
REQ-036 res_ready held low for 10 cycles in RESULT -> res_valid and res_data stable, both readys 0, no mac_valid_in.
REQ-037 reset pulled low during STREAM after 2 beats -> outputs at reset values the same cycle, mac_clear=1, no res_valid; a subsequent job gives the correct sum.
